// File: rtl/datapath_mc_legv8_if.sv
// Bus interface for datapath_mc_legv8: control-word handshake channel and
// single-outstanding memory request channel.
// master = control sequencer / memory side, slave = datapath.
interface datapath_mc_legv8_if #(
   parameter int WIDTH     = 64,
   parameter int REG_COUNT = 32
);
   localparam int AW   = $clog2(REG_COUNT);
   localparam int CW_W = 3 * AW + 15;

   logic             cw_valid;
   logic             cw_ready;
   logic [CW_W-1:0]  control_word;
   logic [WIDTH-1:0] constant;
   logic             mem_req;
   logic             mem_we;
   logic [WIDTH-1:0] mem_addr;
   logic [WIDTH-1:0] mem_wdata;
   logic [WIDTH-1:0] mem_rdata;
   logic             mem_ack;

   modport master (
      output cw_valid, control_word, constant, mem_rdata, mem_ack,
      input  cw_ready, mem_req, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  cw_valid, control_word, constant, mem_rdata, mem_ack,
      output cw_ready, mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/datapath_mc_legv8.sv
// Multi-cycle LEGv8-style datapath: register file, ALU, PC and status flags,
// driven one control word at a time. Register/immediate ops commit on the
// accepting edge; loads and stores park in MEM_WAIT until mem_ack.
// Optional feature macro: DPMC_MEM_TIMEOUT_EN -- abandons a memory access
// after TIMEOUT cycles without mem_ack and raises the sticky mem_err flag.
// Control word layout, LSB upwards: DA, SA, SB, FS[4:0], PS[1:0], WR, WM,
// SL, BSEL, PCSEL, SRC[1:0]; the single MSB above SRC is reserved.
module datapath_mc_legv8 #(
   parameter int WIDTH     = 64,
   parameter int REG_COUNT = 32,
   parameter int TIMEOUT   = 255
) (
   input  logic                clk,
   input  logic                rst_n,
   datapath_mc_legv8_if.slave  bus,
   output logic [WIDTH-1:0]    pc_out,
   output logic [4:0]          status,
   output logic                busy,
   output logic                mem_err
);
   localparam int              AW       = $clog2(REG_COUNT);
   localparam logic [AW-1:0]   ZERO_REG = AW'(REG_COUNT - 1);

   typedef struct packed {
      logic          rsvd;
      logic [1:0]    src;
      logic          pcsel;
      logic          bsel;
      logic          sl;
      logic          wm;
      logic          wr;
      logic [1:0]    ps;
      logic [4:0]    fs;
      logic [AW-1:0] sb;
      logic [AW-1:0] sa;
      logic [AW-1:0] da;
   } cw_t;

   // Fields still needed when a memory op finally commits.
   typedef struct packed {
      logic [1:0]    src;
      logic          sl;
      logic          wm;
      logic          wr;
      logic [1:0]    ps;
      logic [AW-1:0] da;
   } cmt_t;

   typedef struct packed {
      logic v;
      logic c;
      logic n;
      logic z;
   } flags_t;

   typedef enum logic {IDLE, MEM_WAIT} state_t;

   state_t           state, next_state;
   cw_t              cw;
   logic             cw_unused;
   logic [WIDTH-1:0] rf [REG_COUNT];
   logic [WIDTH-1:0] rd_a, rd_b, a_op, b_op, a_in, b_in, alu_res;
   logic [WIDTH:0]   sum;
   flags_t           alu_flags;
   cmt_t             live_c, lat_c, c;
   logic [WIDTH-1:0] lat_alu, lat_b, lat_aop, lat_const;
   flags_t           lat_flags, c_flags;
   logic [WIDTH-1:0] c_alu, c_aop, c_const, wb_data, next_pc, pc, pc_plus4;
   logic [3:0]       status_q;
   logic             mem_op, cw_ready, commit_en, capture_en;

   assign cw        = bus.control_word;
   assign cw_unused = cw.rsvd;
   assign pc_plus4  = pc + WIDTH'(4);

   // Combinational register reads; the top register always reads as zero
   always_comb begin
      rd_a = (cw.sa == ZERO_REG) ? '0 : rf[cw.sa];
      rd_b = (cw.sb == ZERO_REG) ? '0 : rf[cw.sb];
   end

   // Operand selection, optional inversion and the ALU proper
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
      alu_res   = '0;
      alu_flags = '0;
      a_op      = cw.pcsel ? bus.constant : rd_a;
      b_op      = cw.bsel  ? bus.constant : rd_b;
      a_in      = cw.fs[1] ? ~a_op : a_op;
      b_in      = cw.fs[0] ? ~b_op : b_op;
      sum       = {1'b0, a_in} + {1'b0, b_in} + (WIDTH + 1)'(cw.fs[0]);
      case (cw.fs[4:2])
         3'b000:  alu_res = a_in & b_in;
         3'b001:  alu_res = a_in | b_in;
         3'b010:  alu_res = sum[WIDTH-1:0];
         3'b011:  alu_res = a_in ^ b_in;
         3'b100:  alu_res = a_in << b_in[5:0];
         3'b101:  alu_res = a_in >> b_in[5:0];
         default: alu_res = b_in;
      endcase
      alu_flags.z = (alu_res == '0);
      alu_flags.n = alu_res[WIDTH-1];
      if (cw.fs[4:2] == 3'b010) begin
         alu_flags.c = sum[WIDTH];
         alu_flags.v = (a_in[WIDTH-1] == b_in[WIDTH-1]) &&
                       (sum[WIDTH-1] != a_in[WIDTH-1]);
      end
   end

   // Commit fields taken from the incoming control word
   always_comb begin
      live_c     = '0;
      live_c.src = cw.src;
      live_c.sl  = cw.sl;
      live_c.wm  = cw.wm;
      live_c.wr  = cw.wr;
      live_c.ps  = cw.ps;
      live_c.da  = cw.da;
      mem_op     = cw.wm | (cw.src == 2'b01);
   end

`ifdef DPMC_MEM_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] tmo_cnt;
   logic          timeout_hit;
   logic          mem_err_q;
`endif

   // Next-state and handshake decode for the two-state sequencer
   always_comb begin
      next_state = state;
      cw_ready   = 1'b0;
      busy       = 1'b0;
      commit_en  = 1'b0;
      capture_en = 1'b0;
`ifdef DPMC_MEM_TIMEOUT_EN
      timeout_hit = 1'b0;
`endif
      case (state)
         IDLE: begin
            cw_ready = 1'b1;
            if (bus.cw_valid) begin
               if (mem_op) begin
                  capture_en = 1'b1;
                  next_state = MEM_WAIT;
               end else begin
                  commit_en  = 1'b1;
               end
            end
         end
         MEM_WAIT: begin
            busy = 1'b1;
            if (bus.mem_ack) begin
               commit_en  = 1'b1;
               next_state = IDLE;
            end
`ifdef DPMC_MEM_TIMEOUT_EN
            else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
               timeout_hit = 1'b1;
               next_state  = IDLE;
            end
`endif
         end
         default: next_state = IDLE;
      endcase
   end

   // Pick live or latched sources for the commit and form writeback / next PC
   always_comb begin
      if (state == MEM_WAIT) begin
         c       = lat_c;
         c_alu   = lat_alu;
         c_flags = lat_flags;
         c_aop   = lat_aop;
         c_const = lat_const;
      end else begin
         c       = live_c;
         c_alu   = alu_res;
         c_flags = alu_flags;
         c_aop   = a_op;
         c_const = bus.constant;
      end
      wb_data = c_alu;
      case (c.src)
         2'b00: wb_data = c_alu;
         2'b01: wb_data = bus.mem_rdata;
         2'b10: wb_data = pc_plus4;
         2'b11: wb_data = c_const;
      endcase
      next_pc = pc;
      case (c.ps)
         2'b00: next_pc = pc;
         2'b01: next_pc = pc_plus4;
         2'b10: next_pc = c_aop;
         2'b11: next_pc = pc + (c_const << 2);
      endcase
   end

   // Sequencer state register
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state elements use non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   // Hold the memory-op operands steady for the whole access
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_c     <= '0;
         lat_alu   <= '0;
         lat_b     <= '0;
         lat_flags <= '0;
         lat_aop   <= '0;
         lat_const <= '0;
      end else if (capture_en) begin
         lat_c     <= live_c;
         lat_alu   <= alu_res;
         lat_b     <= rd_b;
         lat_flags <= alu_flags;
         lat_aop   <= a_op;
         lat_const <= bus.constant;
      end
   end

   // Register file write port
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the array is inside the async reset because reset must clear every register, so it maps to flops, not RAM.
      if (!rst_n) begin
         for (int i = 0; i < REG_COUNT; i++) rf[i] <= '0;
      end else if (commit_en && c.wr && (c.da != ZERO_REG)) begin
         rf[c.da] <= wb_data;
      end
   end

   // Architectural PC and latched flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc       <= '0;
         status_q <= '0;
      end else if (commit_en) begin
         pc <= next_pc;
         if (c.sl) status_q <= c_flags;
      end
   end

`ifdef DPMC_MEM_TIMEOUT_EN
   // Count unacknowledged MEM_WAIT cycles and record an abandoned access
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt   <= '0;
         mem_err_q <= 1'b0;
      end else begin
         if (state == MEM_WAIT && !bus.mem_ack) tmo_cnt <= tmo_cnt + TW'(1);
         else                                   tmo_cnt <= '0;
         if (timeout_hit) mem_err_q <= 1'b1;
      end
   end
   assign mem_err = mem_err_q;
`else
   assign mem_err = 1'b0;
`endif

   assign bus.cw_ready  = cw_ready;
   assign bus.mem_req   = busy;
   assign bus.mem_we    = busy & lat_c.wm;
   assign bus.mem_addr  = lat_alu;
   assign bus.mem_wdata = lat_b;
   assign pc_out        = pc;
   assign status        = {status_q, alu_flags.z};
endmodule

// File: tb/tb_datapath_mc_legv8.sv
// Directed bench for datapath_mc_legv8 (WIDTH=64, REG_COUNT=32, TIMEOUT=4).
module tb_datapath_mc_legv8;
   localparam int W   = 64;
   localparam int RC  = 32;
   localparam int TMO = 4;
   localparam int CWW = 30;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic [W-1:0] pc_out;
   logic [4:0]   status;
   logic         busy;
   logic         mem_err;
   int           total = 0;
   int           bad   = 0;
   logic [W-1:0] exp_pc;

   datapath_mc_legv8_if #(.WIDTH(W), .REG_COUNT(RC)) bus ();

   datapath_mc_legv8 #(.WIDTH(W), .REG_COUNT(RC), .TIMEOUT(TMO)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus),
      .pc_out  (pc_out),
      .status  (status),
      .busy    (busy),
      .mem_err (mem_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Pack a control word: src, pcsel, bsel, sl, wm, wr, ps, fs, sb, sa, da.
   function automatic logic [CWW-1:0] mk_cw(input int src, pcsel, bsel, sl, wm, wr,
                                            input int ps, fs, sb, sa, da);
      return {1'b0, 2'(src), 1'(pcsel), 1'(bsel), 1'(sl), 1'(wm), 1'(wr),
              2'(ps), 5'(fs), 5'(sb), 5'(sa), 5'(da)};
   endfunction

   // Present one control word for a single accepting edge.
   task automatic issue(input logic [CWW-1:0] cw, input logic [W-1:0] k);
      @(negedge clk);
      bus.control_word = cw;
      bus.constant     = k;
      bus.cw_valid     = 1'b1;
      @(posedge clk);
      #1;
      bus.cw_valid = 1'b0;
   endtask

   task automatic test_reset();
      bus.cw_valid = 1'b0; bus.control_word = '0; bus.constant = '0;
      bus.mem_ack  = 1'b0; bus.mem_rdata    = '0;
      rst_n = 1'b0;
      #12;
      total++; if (pc_out !== '0) begin bad++; $display("FAIL reset_pc: got %h want 0", pc_out); end
      total++; if (status !== 5'b00001) begin bad++; $display("FAIL reset_status: got %b want 00001", status); end
      total++; if (bus.cw_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", bus.cw_ready); end
      total++; if ({bus.mem_req, bus.mem_we, busy, mem_err} !== 4'b0000) begin
         bad++; $display("FAIL reset_mem: got %b want 0000", {bus.mem_req, bus.mem_we, busy, mem_err}); end
      @(negedge clk);
      rst_n  = 1'b1;
      exp_pc = '0;
   endtask

   task automatic test_first_add();
      issue(mk_cw(0, 0, 1, 1, 0, 1, 1, 'b01000, 0, 0, 0), 64'd5);
      exp_pc = 64'd4;
      total++; if (dut.rf[0] !== 64'd5) begin bad++; $display("FAIL add_r0: got %h want 5", dut.rf[0]); end
      total++; if (pc_out !== exp_pc) begin bad++; $display("FAIL add_pc: got %h want %h", pc_out, exp_pc); end
      total++; if (status !== 5'b00000) begin bad++; $display("FAIL add_status: got %b want 00000", status); end
   endtask

   task automatic test_flags();
      issue(mk_cw(3, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1), 64'h7FFF_FFFF_FFFF_FFFF);
      total++; if (dut.rf[1] !== 64'h7FFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL r1_load: got %h", dut.rf[1]); end
      issue(mk_cw(0, 0, 1, 1, 0, 1, 0, 'b01000, 0, 1, 2), 64'd1);
      total++; if (dut.rf[2] !== 64'h8000_0000_0000_0000) begin bad++; $display("FAIL ovf_res: got %h want 8000000000000000", dut.rf[2]); end
      total++; if (status[4:1] !== 4'b1010) begin bad++; $display("FAIL ovf_flags: got %b want 1010", status[4:1]); end
      issue(mk_cw(0, 0, 1, 1, 0, 1, 0, 'b01001, 0, 1, 3), 64'd1);
      total++; if (dut.rf[3] !== 64'h7FFF_FFFF_FFFF_FFFE) begin bad++; $display("FAIL sub_res: got %h want 7ffffffffffffffe", dut.rf[3]); end
      total++; if (status[4:1] !== 4'b0100) begin bad++; $display("FAIL sub_flags: got %b want 0100", status[4:1]); end
      issue(mk_cw(0, 0, 1, 1, 0, 1, 0, 'b01001, 0, 1, 4), 64'h7FFF_FFFF_FFFF_FFFF);
      total++; if (dut.rf[4] !== 64'd0) begin bad++; $display("FAIL subz_res: got %h want 0", dut.rf[4]); end
      total++; if (status[4:1] !== 4'b0101) begin bad++; $display("FAIL subz_flags: got %b want 0101", status[4:1]); end
   endtask

   task automatic test_logic_ops();
      int           fs_t [8] = '{'b00000, 'b00100, 'b01100, 'b10000, 'b10100, 'b11000, 'b00010, 'b11001};
      int           sa_t [8] = '{1, 0, 0, 0, 1, 0, 0, 0};
      logic [W-1:0] k_t  [8] = '{64'hF0, 64'h30, 64'hF, 64'd4, 64'd60, 64'h1234, 64'hFF, 64'h0};
      logic [W-1:0] r_t  [8] = '{64'hF0, 64'h35, 64'hA, 64'h50, 64'h7, 64'h1234, 64'hFA, '1};
      for (int i = 0; i < 8; i++) begin
         issue(mk_cw(0, 0, 1, 0, 0, 1, 0, fs_t[i], 0, sa_t[i], 5 + i), k_t[i]);
         total++;
         if (dut.rf[5 + i] !== r_t[i]) begin
            bad++; $display("FAIL alu_op%0d: got %h want %h", i, dut.rf[5 + i], r_t[i]);
         end
      end
      @(negedge clk);
      bus.control_word = mk_cw(0, 0, 1, 0, 0, 0, 0, 'b00000, 0, 0, 0);
      bus.constant     = 64'd0;
      #1;
      total++; if (status[0] !== 1'b1) begin bad++; $display("FAIL live_zero_set: got %b want 1", status[0]); end
      bus.constant = 64'd1;
      #1;
      total++; if (status[0] !== 1'b0) begin bad++; $display("FAIL live_zero_clr: got %b want 0", status[0]); end
   endtask

   task automatic test_zero_reg();
      issue(mk_cw(3, 0, 0, 0, 0, 1, 0, 0, 0, 0, 31), 64'd99);
      issue(mk_cw(0, 0, 1, 0, 0, 1, 0, 'b01000, 0, 31, 13), 64'd3);
      total++; if (dut.rf[13] !== 64'd3) begin bad++; $display("FAIL zero_reg_a: got %h want 3", dut.rf[13]); end
      issue(mk_cw(0, 0, 0, 0, 0, 1, 0, 'b01000, 31, 0, 14), 64'd0);
      total++; if (dut.rf[14] !== 64'd5) begin bad++; $display("FAIL zero_reg_b: got %h want 5", dut.rf[14]); end
   endtask

   task automatic test_pc();
      issue(mk_cw(0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0), 64'd3);
      total++; if (pc_out !== 64'd16) begin bad++; $display("FAIL pc_branch: got %h want 10", pc_out); end
      issue(mk_cw(0, 1, 0, 0, 0, 0, 2, 0, 0, 0, 0), 64'h100);
      total++; if (pc_out !== 64'h100) begin bad++; $display("FAIL pc_abs: got %h want 100", pc_out); end
      issue(mk_cw(2, 0, 0, 0, 0, 1, 1, 0, 0, 0, 15), 64'd0);
      total++; if (dut.rf[15] !== 64'h104) begin bad++; $display("FAIL link_reg: got %h want 104", dut.rf[15]); end
      total++; if (pc_out !== 64'h104) begin bad++; $display("FAIL link_pc: got %h want 104", pc_out); end
      issue(mk_cw(0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0), '1);
      total++; if (pc_out !== 64'h100) begin bad++; $display("FAIL pc_back: got %h want 100", pc_out); end
      issue(mk_cw(0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0), 64'h0);
      exp_pc = 64'd5;
      total++; if (pc_out !== exp_pc) begin bad++; $display("FAIL pc_reg: got %h want %h", pc_out, exp_pc); end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      bus.control_word = mk_cw(3, 0, 0, 0, 0, 1, 0, 0, 0, 0, 16);
      bus.constant = 64'd7; bus.cw_valid = 1'b1;
      @(posedge clk); #1;
      total++; if (dut.rf[16] !== 64'd7 || bus.cw_ready !== 1'b1) begin
         bad++; $display("FAIL b2b_first: got %h/%b want 7/1", dut.rf[16], bus.cw_ready); end
      @(negedge clk);
      bus.control_word = mk_cw(0, 0, 1, 0, 0, 1, 0, 'b01000, 0, 16, 17);
      bus.constant = 64'd1;
      @(posedge clk); #1;
      total++; if (dut.rf[17] !== 64'd8) begin bad++; $display("FAIL b2b_second: got %h want 8", dut.rf[17]); end
      @(negedge clk);
      bus.control_word = mk_cw(0, 0, 1, 0, 0, 1, 0, 'b01000, 0, 17, 17);
      @(posedge clk); #1;
      bus.cw_valid = 1'b0;
      total++; if (dut.rf[17] !== 64'd9) begin bad++; $display("FAIL b2b_rmw: got %h want 9", dut.rf[17]); end
   endtask

   task automatic test_store();
      issue(mk_cw(0, 0, 1, 0, 1, 0, 1, 'b01000, 0, 0, 0), 64'h10);
      total++; if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {2'b11, 64'h15, 64'd5}) begin
         bad++; $display("FAIL store_bus: got %b%b %h %h want 11 15 5", bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata); end
      total++; if (pc_out !== exp_pc) begin bad++; $display("FAIL store_early_pc: got %h want %h", pc_out, exp_pc); end
      bus.mem_ack = 1'b1;
      @(posedge clk); #1;
      bus.mem_ack = 1'b0;
      exp_pc = exp_pc + 64'd4;
      total++; if (busy !== 1'b0 || pc_out !== exp_pc) begin
         bad++; $display("FAIL store_done: got busy=%b pc=%h want 0 %h", busy, pc_out, exp_pc); end
   endtask

   task automatic test_load();
      int ready_low = 0;
      issue(mk_cw(1, 0, 1, 0, 0, 1, 1, 'b01000, 0, 0, 18), 64'h40);
      bus.control_word = '1;
      bus.constant     = '0;
      for (int i = 0; i < 10 && bus.cw_ready !== 1'b1; i++) begin
         ready_low++;
         total++;
         if ({bus.mem_req, bus.mem_we, busy} !== 3'b101 || bus.mem_addr !== 64'h45) begin
            bad++; $display("FAIL load_wait%0d: got req/we/busy=%b addr=%h want 101 45", i,
                            {bus.mem_req, bus.mem_we, busy}, bus.mem_addr);
         end
         total++;
         if (dut.rf[18] !== 64'd0 || pc_out !== exp_pc) begin
            bad++; $display("FAIL load_early%0d: got r18=%h pc=%h want 0 %h", i, dut.rf[18], pc_out, exp_pc);
         end
         if (ready_low == 3) begin
            bus.mem_ack = 1'b1; bus.mem_rdata = 64'hDEAD;
         end
         @(posedge clk); #1;
         bus.mem_ack = 1'b0; bus.mem_rdata = '0;
      end
      exp_pc = exp_pc + 64'd4;
      total++; if (ready_low !== 3) begin bad++; $display("FAIL load_ready_low: got %0d want 3", ready_low); end
      total++; if (dut.rf[18] !== 64'hDEAD) begin bad++; $display("FAIL load_data: got %h want dead", dut.rf[18]); end
      total++; if ({busy, bus.mem_req, mem_err} !== 3'b000 || pc_out !== exp_pc) begin
         bad++; $display("FAIL load_done: got busy/req/err=%b pc=%h want 000 %h", {busy, bus.mem_req, mem_err}, pc_out, exp_pc); end
      bus.control_word = '0;
   endtask

   task automatic test_store_reset();
      issue(mk_cw(0, 0, 1, 0, 1, 0, 1, 'b01000, 0, 0, 0), 64'h20);
      total++; if ({bus.mem_req, bus.mem_we} !== 2'b11) begin bad++; $display("FAIL sr_req: got %b want 11", {bus.mem_req, bus.mem_we}); end
      #2;
      rst_n = 1'b0;
      #1;
      total++; if ({bus.mem_req, bus.mem_we, busy, bus.cw_ready} !== 4'b0001) begin
         bad++; $display("FAIL sr_abort: got req/we/busy/rdy=%b want 0001", {bus.mem_req, bus.mem_we, busy, bus.cw_ready}); end
      total++; if (pc_out !== '0 || dut.rf[0] !== '0) begin bad++; $display("FAIL sr_state: got pc=%h r0=%h want 0 0", pc_out, dut.rf[0]); end
      @(negedge clk);
      rst_n = 1'b1;
      bus.control_word = mk_cw(0, 0, 1, 1, 0, 1, 1, 'b01000, 0, 0, 0);
      bus.constant = 64'd5; bus.cw_valid = 1'b1;
      @(posedge clk); #1;
      bus.cw_valid = 1'b0;
      exp_pc = 64'd4;
      total++; if (dut.rf[0] !== 64'd5 || pc_out !== exp_pc) begin
         bad++; $display("FAIL sr_first_accept: got r0=%h pc=%h want 5 4", dut.rf[0], pc_out); end
   endtask

`ifdef DPMC_MEM_TIMEOUT_EN
   task automatic test_timeout();
      int req_cycles = 0;
      issue(mk_cw(1, 0, 1, 0, 0, 1, 1, 'b01000, 0, 0, 19), 64'd0);
      for (int i = 0; i < 20 && bus.mem_req === 1'b1; i++) begin
         req_cycles++;
         @(posedge clk); #1;
      end
      total++; if (req_cycles !== TMO) begin bad++; $display("FAIL tmo_cycles: got %0d want %0d", req_cycles, TMO); end
      total++; if ({mem_err, bus.cw_ready, busy} !== 3'b110) begin
         bad++; $display("FAIL tmo_flags: got err/rdy/busy=%b want 110", {mem_err, bus.cw_ready, busy}); end
      total++; if (pc_out !== exp_pc || dut.rf[19] !== '0) begin
         bad++; $display("FAIL tmo_nocommit: got pc=%h r19=%h want %h 0", pc_out, dut.rf[19], exp_pc); end
      issue(mk_cw(0, 0, 1, 0, 0, 0, 1, 'b01000, 0, 0, 0), 64'd0);
      exp_pc = exp_pc + 64'd4;
      total++; if (mem_err !== 1'b1 || pc_out !== exp_pc) begin
         bad++; $display("FAIL tmo_sticky: got err=%b pc=%h want 1 %h", mem_err, pc_out, exp_pc); end
   endtask
`endif

   initial begin
      test_reset();
      test_first_add();
      test_flags();
      test_logic_ops();
      test_zero_reg();
      test_pc();
      test_back_to_back();
      test_store();
      test_load();
      test_store_reset();
`ifdef DPMC_MEM_TIMEOUT_EN
      test_timeout();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/datapath_mc_legv8.md
DATAPATH_MC_LEGV8 -- requirements
Module: datapath_mc_legv8

Interface
REQ-001 Parameter WIDTH, default 64, data/address/register width in bits (>=8).
REQ-002 Parameter REG_COUNT, default 32, register count (power of two, >=4); AW = log2(REG_COUNT).
REQ-003 Parameter TIMEOUT, default 255, memory-wait cycle limit (used only under REQ-030).
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 cw_valid  input  1  control word present.
REQ-007 cw_ready  output  1  control word accepted when cw_valid & cw_ready at the rising edge.
REQ-008 control_word  input  3*AW+15  fields MSB->LSB: SRC[1:0], PCSEL, BSEL, SL, WM, WR, PS[1:0], FS[4:0], SB, SA, DA (AW bits each).
REQ-009 constant  input  WIDTH  immediate operand.
REQ-010 mem_req/mem_we  output  1/1  memory request, write strobe.
REQ-011 mem_addr/mem_wdata  output  WIDTH/WIDTH  address = ALU result, write data = register SB.
REQ-012 mem_rdata/mem_ack  input  WIDTH/1  read data, completion (valid same cycle as ack).
REQ-013 pc_out  output  WIDTH  current PC.
REQ-014 status  output  5  {V,C,N,Z} latched in [4:1]; [0] = live ALU zero.
REQ-015 busy/mem_err  output  1/1  memory op outstanding; timeout error sticky flag.

Function
REQ-016 Register file: REG_COUNT x WIDTH, two combinational reads (SA->A, SB->B); register REG_COUNT-1 reads 0, writes ignored.
REQ-017 Operand B_op = BSEL ? constant : B; operand A_op = PCSEL ? constant : A.
REQ-018 ALU: FS[1] inverts A_op, FS[0] inverts B_op and is carry-in; FS[4:2]: 000 AND, 001 OR, 010 ADD, 011 XOR, 100 A<<B[5:0], 101 A>>B[5:0] logical, 110/111 pass B_op.
REQ-019 Flags: Z = result==0, N = result MSB, C = adder carry-out (0 unless ADD), V = signed overflow (0 unless ADD).
REQ-020 Writeback data by SRC: 00 ALU result, 01 mem_rdata, 10 PC+4 (pre-update PC), 11 constant.
REQ-021 FSM states IDLE, MEM_WAIT; cw_ready = 1 only in IDLE.
REQ-022 IDLE accept, WM=0 and SRC!=01: commit same edge -- register write if WR, status[4:1] load if SL, PC update; stay IDLE (latency 1 cycle).
REQ-023 IDLE accept, WM=1 or SRC=01: latch control word, ALU result, B; go MEM_WAIT; no commit yet.
REQ-024 MEM_WAIT: mem_req=1, mem_we=latched WM, busy=1; address/data stable until ack.
REQ-025 MEM_WAIT with mem_ack: commit per REQ-022 using latched fields (load data from mem_rdata); return IDLE next cycle; mem_req low in IDLE.
REQ-026 PC update by PS: 00 hold, 01 PC+4, 10 A_op, 11 PC+(constant<<2); all arithmetic modulo 2^WIDTH.
REQ-027 Register write and read of same index same cycle: read returns old value.

Reset
REQ-028 reset low: state IDLE, PC=0, all registers 0, status[4:1]=0, mem_req/mem_we/busy/mem_err=0, immediately and independent of clock.
REQ-029 reset during MEM_WAIT aborts the access with no commit; first accept possible on first rising edge after release.

Configuration
REQ-030 DPMC_MEM_TIMEOUT_EN defined: counter in MEM_WAIT; TIMEOUT cycles without mem_ack -> drop request, no commit, set mem_err (sticky until reset), return IDLE.
REQ-031 DPMC_MEM_TIMEOUT_EN undefined: MEM_WAIT waits indefinitely; mem_err tied 0; no counter logic.

Verification
REQ-032 After reset, DA=0, FS=01000 (ADD), BSEL=1, constant=5, WR=1, SL=1, PS=01 -> R0=5, status=5'b00000, pc_out=4 after one edge.
REQ-033 R1=0x7FFF..FF, ADD R1+BSEL const 1, SL=1 -> result 0x8000..00, status[4:1]={V=1,C=0,N=1,Z=0}.
REQ-034 Load SRC=01, mem_ack after 3 cycles with rdata=0xDEAD -> cw_ready low 3 cycles, register written 0xDEAD on ack edge, busy then low.
REQ-035 Store WM=1 then reset pulsed in MEM_WAIT -> mem_req falls asynchronously, no register/PC change, pc_out=0.
REQ-036 DPMC_MEM_TIMEOUT_EN, TIMEOUT=4, no ack -> mem_req high exactly 4 cycles, mem_err=1, PC unchanged, cw_ready=1.
